// File: rtl/nsc8_display_pkg.sv
// -----------------------------------------------------------------------------
// nsc8_display_pkg
//   Shared definitions for the output display block:
//     - FSM state encoding for the sequential binary-to-BCD converter
//     - 7-segment codes in {g,f,e,d,c,b,a} order, active-high
//     - Digit count and double-dabble iteration count
//     - seg_decode(): BCD digit to segment pattern
//   Configuration macro (used by output_display): SIGNED_DISPLAY_EN
// -----------------------------------------------------------------------------
package nsc8_display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } bcd_state_e;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_ITER   = 8;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_MINUS = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Non-decimal nibbles cannot come out of the converter; they map to blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//   Sequential double-dabble converter: 8-bit binary to 3 BCD digits,
//   one iteration per clock.
//   Timing: start_i sampled at E0; iterations on E1..E8; done_o is high
//   for the single cycle after E8 (COMMIT state); busy_o drops at E9.
//   A start_i in any state restarts with the new operand.
//   Ports:
//     clk      base clock
//     reset    asynchronous active-high reset
//     start_i  load bin_i and begin a conversion
//     bin_i    8-bit operand
//     busy_o   conversion in progress (E0 up to E9)
//     done_o   bcd_o is final; consumer latches it on the next edge
//     bcd_o    {hundreds, tens, ones}
// -----------------------------------------------------------------------------
module bin_to_bcd_seq
    import nsc8_display_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [7:0]  bin_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [11:0] bcd_o
);

    localparam int ITER_W = $clog2(BCD_ITER);

    bcd_state_e        state_q;
    logic [ITER_W-1:0] iter_q;
    // {hundreds, tens, ones, binary remainder}
    logic [19:0]       sr_q;
    logic [19:0]       sr_adj;
    logic              busy_q;
    logic              done_q;

    // Add-3 correction for every BCD nibble >= 5, applied before the shift.
    // NOTE: combinational logic uses blocking '=' with a full default first,
    // so no latch is inferred; clocked state below uses '<=' only.
    always_comb begin
        sr_adj = sr_q;
        for (int k = 0; k < 3; k++) begin
            if (sr_q[8 + 4*k +: 4] >= 4'd5) begin
                sr_adj[8 + 4*k +: 4] = sr_q[8 + 4*k +: 4] + 4'd3;
            end
        end
    end

    // NOTE: the shift register is reset along with the control state so that
    // an aborted conversion leaves no stale digits behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            iter_q  <= '0;
            sr_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                // Latest write wins, including over a pending COMMIT.
                sr_q    <= {12'b0, bin_i};
                iter_q  <= '0;
                state_q <= SHIFT;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    SHIFT: begin
                        sr_q   <= {sr_adj[18:0], 1'b0};
                        iter_q <= iter_q + 1'b1;
                        if (iter_q == ITER_W'(BCD_ITER - 1)) begin
                            state_q <= COMMIT;
                            done_q  <= 1'b1;
                        end
                    end
                    COMMIT: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign bcd_o  = sr_q[19:8];

endmodule

// File: rtl/output_display.sv
// -----------------------------------------------------------------------------
// output_display
//   Captures the bus on the OUT strobe, converts it to BCD and drives a
//   4-digit multiplexed 7-segment display. Runs from the ungated base clock
//   so the result remains visible after the machine halts.
//   Configuration macro: SIGNED_DISPLAY_EN
//     defined   - bus is two's complement; digit3 shows minus for negatives
//     undefined - bus is unsigned 0..255; digit3 is always blank
//   Parameters:
//     SCAN_DIV   cycles each digit stays enabled (>= 2)
//     ACTIVE_LOW 1 inverts seg and an at the pins
//   Ports:
//     clk                  ungated base clock
//     reset                asynchronous active-high reset
//     bus                  shared 8-bit data bus
//     write_enable_output  capture strobe
//     out_value            last captured raw bus value
//     busy                 conversion in progress
//     seg                  segments {g,f,e,d,c,b,a}
//     an                   one-hot digit enable, an[0] = ones
// -----------------------------------------------------------------------------
module output_display
    import nsc8_display_pkg::*;
#(
    parameter int SCAN_DIV   = 1024,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            bus,
    input  logic                  write_enable_output,
    output logic [7:0]            out_value,
    output logic                  busy,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [7:0]       out_value_q;
    logic [7:0]       magnitude;
    logic             conv_done;
    logic [11:0]      conv_bcd;
    logic [3:0]       ones_q;
    logic [3:0]       tens_q;
    logic [3:0]       hund_q;
    logic [CNT_W-1:0] scan_cnt_q;
    logic [1:0]       digit_q;
    logic [6:0]       seg_raw;
    logic [3:0]       an_raw;

`ifdef SIGNED_DISPLAY_EN
    logic             sign_q;

    // Two's-complement negate; 8'h80 maps to 8'h80, read as 128.
    assign magnitude = bus[7] ? (~bus + 8'd1) : bus;
`else
    assign magnitude = bus;
`endif

    bin_to_bcd_seq u_bcd (
        .clk     (clk),
        .reset   (reset),
        .start_i (write_enable_output),
        .bin_i   (magnitude),
        .busy_o  (busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    // Capture register and display digits. A write on the commit edge
    // restarts the converter, so the stale result must not be latched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_value_q <= '0;
            ones_q      <= '0;
            tens_q      <= '0;
            hund_q      <= '0;
`ifdef SIGNED_DISPLAY_EN
            sign_q      <= 1'b0;
`endif
        end else begin
            if (write_enable_output) begin
                out_value_q <= bus;
            end
            if (conv_done && !write_enable_output) begin
                hund_q <= conv_bcd[11:8];
                tens_q <= conv_bcd[7:4];
                ones_q <= conv_bcd[3:0];
`ifdef SIGNED_DISPLAY_EN
                // out_value_q still holds the operand being committed.
                sign_q <= out_value_q[7];
`endif
            end
        end
    end

    // Digit scan: free-running, independent of writes and conversions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt_q <= '0;
            digit_q    <= '0;
        end else if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt_q <= '0;
            digit_q    <= digit_q + 2'd1;
        end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
        end
    end

    // Segment select with leading-zero blanking; ones is always shown.
    always_comb begin
        seg_raw = SEG_BLANK;
        an_raw  = 4'b0001 << digit_q;
        case (digit_q)
            2'd0: seg_raw = seg_decode(ones_q);
            2'd1: if (hund_q != 4'd0 || tens_q != 4'd0) seg_raw = seg_decode(tens_q);
            2'd2: if (hund_q != 4'd0) seg_raw = seg_decode(hund_q);
`ifdef SIGNED_DISPLAY_EN
            2'd3: seg_raw = sign_q ? SEG_MINUS : SEG_BLANK;
`endif
            default: seg_raw = SEG_BLANK;
        endcase
    end

    assign seg       = ACTIVE_LOW ? ~seg_raw : seg_raw;
    assign an        = ACTIVE_LOW ? ~an_raw  : an_raw;
    assign out_value = out_value_q;

endmodule

// File: tb/tb_output_display.sv
// -----------------------------------------------------------------------------
// tb_output_display
//   Drives output_display with directed scenarios and random writes/resets,
//   comparing every cycle against a value-level model (decimal arithmetic on
//   the last committed number plus a scan position derived from elapsed
//   cycles), with literal spot checks on the key scenarios.
// -----------------------------------------------------------------------------
module tb_output_display;

    localparam int SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] bus = 8'd0;
    logic       we = 1'b0;
    logic [7:0] out_value;
    logic       busy;
    logic [6:0] seg;
    logic [3:0] an;

    int total = 0;
    int bad   = 0;

    output_display #(.SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(1'b0)) dut (
        .clk                 (clk),
        .reset               (reset),
        .bus                 (bus),
        .write_enable_output (we),
        .out_value           (out_value),
        .busy                (busy),
        .seg                 (seg),
        .an                  (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0] segs [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                              7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    int     m_out     = 0;
    int     m_pending = 0;
    int     m_shown   = 0;
    int     m_remain  = 0;
    longint m_scan    = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_out    = 0;
            m_shown  = 0;
            m_remain = 0;
            m_scan   = 0;
        end else begin
            m_scan++;
            if (we) begin
                m_out     = bus;
                m_pending = bus;
                m_remain  = 9;
            end else if (m_remain > 0) begin
                m_remain--;
                if (m_remain == 0) m_shown = m_pending;
            end
        end
    end

    function automatic logic [6:0] exp_seg(input int d, input int shown);
        int mag;
        bit neg;
`ifdef SIGNED_DISPLAY_EN
        neg = (shown >= 128);
        mag = neg ? 256 - shown : shown;
`else
        neg = 1'b0;
        mag = shown;
`endif
        case (d)
            0:       return segs[mag % 10];
            1:       return (mag >= 10)  ? segs[(mag / 10) % 10] : 7'b0000000;
            2:       return (mag >= 100) ? segs[mag / 100]       : 7'b0000000;
            default: return neg ? 7'b1000000 : 7'b0000000;
        endcase
    endfunction

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        automatic int d = int'((m_scan / SCAN_DIV) % 4);
        automatic logic [3:0] exp_an = 4'b0001 << d;
        check("an", {28'd0, an}, {28'd0, exp_an});
        check("seg", {25'd0, seg}, {25'd0, exp_seg(d, m_shown)});
        check("out_value", {24'd0, out_value}, m_out);
        check("busy", {31'd0, busy}, {31'd0, (m_remain != 0)});
    end

    // ---------------- stimulus helpers ----------------
    // All tasks start and end at posedge+2.
    task automatic write(input logic [7:0] v);
        bus = v;
        we  = 1'b1;
        @(posedge clk); #2;
        we  = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic see_digit(input int d, input logic [6:0] exp, input string name);
        automatic logic [3:0] target = 4'b0001 << d;
        for (int i = 0; i < 4 * SCAN_DIV + 2; i++) begin
            if (an == target) break;
            cycles(1);
        end
        check({name, "_an"}, {28'd0, an}, {28'd0, target});
        check(name, {25'd0, seg}, {25'd0, exp});
    endtask

    task automatic reset_idle_checks(input string name);
        check({name, "_an"}, {28'd0, an}, 32'h1);
        check({name, "_seg"}, {25'd0, seg}, {25'd0, 7'b0111111});
        check({name, "_out"}, {24'd0, out_value}, 32'd0);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        cycles(3);
        reset_idle_checks("rst");
        cycles(100);
        reset_idle_checks("rst_hold");
        reset = 1'b0;
        cycles(2);

        // 157: busy over E0..E8, low after E9, then the four digits
        write(8'd157);
        check("busy_E0", {31'd0, busy}, 32'd1);
        for (int i = 1; i <= 8; i++) begin
            cycles(1);
            check("busy_Ek", {31'd0, busy}, 32'd1);
        end
        cycles(1);
        check("busy_E9", {31'd0, busy}, 32'd0);
        see_digit(0, 7'b0000111, "d157_0");
        see_digit(1, 7'b1101101, "d157_1");
        see_digit(2, 7'b0000110, "d157_2");
        see_digit(3, 7'b0000000, "d157_3");

        write(8'd7);
        cycles(9);
        see_digit(0, 7'b0000111, "d7_0");
        see_digit(1, 7'b0000000, "d7_1");
        see_digit(2, 7'b0000000, "d7_2");
        see_digit(3, 7'b0000000, "d7_3");

        write(8'd0);
        cycles(9);
        see_digit(0, 7'b0111111, "d0_0");

        // 200 then 42 at E4: 42 wins
        write(8'd200);
        cycles(3);
        write(8'd42);
        cycles(9);
        check("restart_out", {24'd0, out_value}, 32'd42);
        see_digit(0, 7'b1011011, "d42_0");
        see_digit(1, 7'b1100110, "d42_1");
        see_digit(2, 7'b0000000, "d42_2");

        write(8'hFF);
        cycles(9);
`ifdef SIGNED_DISPLAY_EN
        see_digit(0, 7'b0000110, "dFF_0");
        see_digit(1, 7'b0000000, "dFF_1");
        see_digit(3, 7'b1000000, "dFF_3");
`else
        see_digit(0, 7'b1101101, "dFF_0");
        see_digit(1, 7'b1101101, "dFF_1");
        see_digit(2, 7'b1011011, "dFF_2");
        see_digit(3, 7'b0000000, "dFF_3");
`endif
        check("outFF", {24'd0, out_value}, 32'hFF);

        write(8'h80);
        cycles(9);
`ifdef SIGNED_DISPLAY_EN
        see_digit(0, 7'b1111111, "d80_0");
        see_digit(1, 7'b1011011, "d80_1");
        see_digit(2, 7'b0000110, "d80_2");
        see_digit(3, 7'b1000000, "d80_3");
`else
        see_digit(0, 7'b1111111, "d80_0");
        see_digit(1, 7'b1011011, "d80_1");
        see_digit(2, 7'b0000110, "d80_2");
        see_digit(3, 7'b0000000, "d80_3");
`endif

        // Reset during conversion of 99
        write(8'd99);
        cycles(4);
        reset = 1'b1;
        #1;
        reset_idle_checks("abort");
        cycles(2);
        reset = 1'b0;
        cycles(1);
        write(8'd3);
        cycles(8);
        check("d3_busy_E8", {31'd0, busy}, 32'd1);
        cycles(1);
        check("d3_busy_E9", {31'd0, busy}, 32'd0);
        see_digit(0, 7'b1001111, "d3_0");
        see_digit(1, 7'b0000000, "d3_1");

        // Random writes, overlapping restarts and occasional resets
        for (int n = 0; n < 300; n++) begin
            cycles($urandom_range(0, 14));
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                cycles(2);
                reset = 1'b0;
            end
            write(8'($urandom_range(0, 255)));
        end
        cycles(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/output_display.md
Name: output_display

Overview:
- Downstream consumer of the controller's OUT micro-operation.
- Captures the 8-bit bus value when `write_enable_output` is asserted and converts it to BCD with a sequential double-dabble engine.
- Drives a 4-digit multiplexed 7-segment display, so the halted machine's result stays visible.
- Clocked from the free-running base clock, not the HLT-gated `clk`, so scanning continues after HLT.

Parameters:
- SCAN_DIV, 1024, clock cycles each digit stays enabled before the scan advances (≥2).
- ACTIVE_LOW, 0, 1 inverts both `seg` and `an` at the outputs.

Ports:
- clk  input  1  ungated base clock
- reset  input  1  asynchronous, active-high; clears all state
- bus  input  8  shared data bus (A register during OUT)
- write_enable_output  input  1  controller strobe; capture `bus` on this edge
- out_value  output  8  last captured bus value
- busy  output  1  conversion in progress
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high unless ACTIVE_LOW
- an  output  4  one-hot digit enable, an[0] = ones … an[3] = sign/blank

Behaviour:
- Reset: `out_value`=0, BCD display registers = 0, `busy`=0, FSM=IDLE, scan counter=0, digit select=0. Outputs show `an`=0001, `seg`=0111111 ('0').
- FSM states: IDLE, SHIFT, COMMIT.
- Capture (edge E0), `write_enable_output`=1 in any state:
  - `out_value` <= `bus`.
  - Shift register <= {12'b0, magnitude}.
  - Iteration count <= 0; FSM -> SHIFT; `busy`=1 from E0.
- SHIFT, edges E1..E8, one per cycle: add 3 to each BCD nibble ≥5, then shift left 1. After the 8th iteration FSM -> COMMIT.
- COMMIT (E9): copy hundreds/tens/ones and the sign flag into the display registers; FSM -> IDLE; `busy`=0. New digits are visible from E9.
- Latency: capture to display = 9 cycles.
- Display registers change only at COMMIT; mid-conversion values never reach `seg`.
- Write during SHIFT/COMMIT restarts the conversion with the new value (latest wins). The old value is never committed; the restart edge's write takes priority over COMMIT.
- Scan:
  - Counter counts 0..SCAN_DIV-1, wraps, and on wrap advances digit select 0→1→2→3→0.
  - Scan is independent of the FSM and of writes.
- Digit mapping: digit0 = ones (always shown, including 0); digit1 = tens; digit2 = hundreds; digit3 = sign slot.
- Leading-zero blanking: hundreds blank if 0; tens blank if hundreds=0 and tens=0. Blank = `seg` 0000000.
- Segment codes (gfedcba): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, minus=1000000.
- Reset mid-conversion aborts immediately; nothing is committed.

Optional Feature:
- SIGNED_DISPLAY_EN defined:
  - `bus` is two's complement; magnitude = bit7 ? -bus : bus (8'h80 → 128).
  - Sign flag = bit7; digit3 shows minus when the flag is set, else blank.
- Undefined:
  - Unsigned 0..255; digit3 always blank; sign logic absent.
- `out_value` always holds the raw `bus` bits in both builds.

Decomposition:
- Package nsc8_display_pkg:
  - FSM state enum.
  - Segment constants SEG_0..SEG_9, SEG_MINUS, SEG_BLANK.
  - NUM_DIGITS=4, BCD_ITER=8.
- Sub-module bin_to_bcd_seq: the double-dabble FSM with start/busy/done and 12-bit BCD out.
- Scan counter, blanking and segment decode stay in output_display.

Test Plan:
- Reset → `an`=0001, `seg`=0111111, `out_value`=0, `busy`=0; hold reset 100 cycles → outputs unchanged.
- Write 157 (SCAN_DIV=4) → `busy` high E0..E8, low after E9. Scan then shows:
  - `an`=0001 `seg`=0000111
  - `an`=0010 `seg`=1101101
  - `an`=0100 `seg`=0000110
  - `an`=1000 `seg`=0000000
- Write 7 → digit0 `seg`=0000111; digits 1,2,3 `seg`=0000000. Write 0 → digit0 shows 0111111.
- Write 200, then write 42 at E4 → display 42 from 9 cycles after the second write; 200 never appears; `out_value`=42.
- SIGNED_DISPLAY_EN: 8'hFF → digit0 0000110, digit3 1000000; 8'h80 → 1,2,8 plus minus. Without macro: 8'hFF → 2,5,5, digit3 blank.
- Assert reset at E5 of converting 99 → display reverts to '0', `busy`=0; after release, write 3 → shows 3 at E9.
